// File: rtl/accel_pkg.sv
// Shared definitions for the Accel host-side launcher: register map, status layout,
// FSM states and configuration field widths.
package accel_pkg;

  // Register addresses
  localparam logic [2:0] AddrImageDim   = 3'd0;
  localparam logic [2:0] AddrImageDepth = 3'd1;
  localparam logic [2:0] AddrImageOff   = 3'd2;
  localparam logic [2:0] AddrFilterOff  = 3'd3;
  localparam logic [2:0] AddrFilterCfg  = 3'd4;
  localparam logic [2:0] AddrBias       = 3'd5;
  localparam logic [2:0] AddrCtrl       = 3'd6;
  localparam logic [2:0] AddrStatus     = 3'd7;

  // Control and status bit positions
  localparam int unsigned CtrlStartBit  = 0;
  localparam int unsigned CtrlClearBit  = 1;
  localparam int unsigned StatusBusyBit = 0;
  localparam int unsigned StatusDoneBit = 1;
  localparam int unsigned StatusErrBit  = 2;
  localparam int unsigned StatusLenLsb  = 16;

  // Configuration field widths
  localparam int unsigned DimW      = 8;
  localparam int unsigned DepthW    = 9;
  localparam int unsigned OffsetW   = 16;
  localparam int unsigned HalfsizeW = 2;
  localparam int unsigned StrideW   = 3;
  localparam int unsigned LengthW   = 13;
  localparam int unsigned BiasW     = 18;

  // Multiplier operand/result widths
  localparam int unsigned KsqW  = 6;
  localparam int unsigned ProdW = 15;

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StCalc,
    StLaunch,
    StRun,
    StDrain,
    StDone
  } state_e;

  // Square of the filter edge k = 2*halfsize + 1
  function automatic logic [KsqW-1:0] ksq_of(input logic [HalfsizeW-1:0] hs);
    logic [KsqW-1:0] k2;
    unique case (hs)
      2'd0:    k2 = 6'd1;
      2'd1:    k2 = 6'd9;
      2'd2:    k2 = 6'd25;
      default: k2 = 6'd49;
    endcase
    return k2;
  endfunction

endpackage

// File: rtl/filter_length_calc.sv
// Sequential shift-add multiplier: depth * k^2, one multiplier bit per cycle over six
// cycles (bit 0 is folded into the load cycle). valid pulses for one cycle with the result.
module filter_length_calc
  import accel_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DepthW-1:0] depth,
  input  logic [KsqW-1:0]   ksq,
  output logic              busy,
  output logic              valid,
  output logic [ProdW-1:0]  result,
  output logic              overflow
);

  logic [ProdW-1:0] acc_q, mcand_q;
  logic [KsqW-2:0]  mplier_q;
  logic [2:0]       step_q;
  logic             busy_q, valid_q;

  // Load operands on start, then add one shifted partial product per cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      step_q   <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (start) begin
        acc_q    <= ksq[0] ? ProdW'(depth) : '0;
        mcand_q  <= ProdW'(depth) << 1;
        mplier_q <= ksq[KsqW-1:1];
        step_q   <= '0;
        busy_q   <= 1'b1;
      end else if (busy_q) begin
        if (mplier_q[0]) acc_q <= acc_q + mcand_q;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        step_q   <= step_q + 3'd1;
        if (step_q == 3'd4) begin
          busy_q  <= 1'b0;
          valid_q <= 1'b1;
        end
      end
    end
  end

  assign busy     = busy_q;
  assign valid    = valid_q;
  assign result   = acc_q;
  // Anything above 13 bits cannot be represented in filter_length
  assign overflow = |acc_q[ProdW-1:LengthW];

endmodule

// File: rtl/accel_launcher.sv
// Host-side launcher for the Accel engine: CPU register port, derived filter_length,
// Accel reset sequencing, post-done drain window, status and interrupt.
module accel_launcher
  import accel_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES   = 10,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic                 rd_en,
  input  logic [2:0]           addr,
  input  logic [31:0]          wr_data,
  output logic [31:0]          rd_data,
  output logic                 irq,
  output logic                 accel_rst,
  output logic [DimW-1:0]      image_dim,
  output logic [DepthW-1:0]    image_depth,
  output logic [OffsetW-1:0]   image_memory_offset,
  output logic [OffsetW-1:0]   filter_memory_offset,
  output logic [HalfsizeW-1:0] filter_halfsize,
  output logic [StrideW-1:0]   filter_stride,
  output logic [LengthW-1:0]   filter_length,
  output logic [BiasW-1:0]     filter_bias,
  input  logic                 accel_done
);

  state_e             state_q, state_d;
  logic               start_q;
  logic               done_q, done_d, err_q, err_d, irq_d;
  logic [31:0]        cnt_q, cnt_d;
  logic [LengthW-1:0] len_d;
  logic               busy, cfg_wr, ctrl_wr, start_req, clear_req, cfg_bad;
  logic               mul_start, mul_busy, mul_valid, mul_ovf;
  logic [ProdW-1:0]   mul_result;
  logic [31:0]        status, rd_mux;
  logic               unused_bits;

  assign busy      = (state_q != StIdle);
  assign cfg_wr    = wr_en && !busy && (addr < AddrCtrl);
  assign ctrl_wr   = wr_en && (addr == AddrCtrl);
  assign start_req = ctrl_wr && wr_data[CtrlStartBit] && !busy;
  assign clear_req = ctrl_wr && wr_data[CtrlClearBit];
  assign cfg_bad   = (image_dim == '0) || (image_depth == '0) || (filter_stride == '0);
  // Accel is only out of reset while it runs and while its last outputs drain
  assign accel_rst = !((state_q == StRun) || (state_q == StDrain));
  assign unused_bits = ^{wr_data[31:BiasW], mul_result[ProdW-1:LengthW]};

  filter_length_calc u_calc (
    .clk      (clk),
    .rst      (rst),
    .start    (mul_start),
    .depth    (image_depth),
    .ksq      (ksq_of(filter_halfsize)),
    .busy     (mul_busy),
    .valid    (mul_valid),
    .result   (mul_result),
    .overflow (mul_ovf)
  );

  // Next-state, sticky status flags and interrupt request
  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    done_d    = done_q;
    irq_d     = 1'b0;
    cnt_d     = cnt_q;
    len_d     = filter_length;
    mul_start = 1'b0;
    if (clear_req) begin
      err_d  = 1'b0;
      done_d = 1'b0;
    end
    unique case (state_q)
      StIdle: if (start_q) state_d = StCheck;
      StCheck: begin
        if (cfg_bad) begin
          err_d   = 1'b1;
          irq_d   = 1'b1;
          state_d = StIdle;
        end else begin
          mul_start = 1'b1;
          state_d   = StCalc;
        end
      end
      StCalc: begin
        if (mul_valid && !mul_busy) begin
          if (mul_ovf) begin
            err_d   = 1'b1;
            irq_d   = 1'b1;
            state_d = StIdle;
          end else begin
            len_d   = mul_result[LengthW-1:0];
            state_d = StLaunch;
          end
        end
      end
      StLaunch: begin
        cnt_d   = '0;
        state_d = StRun;
      end
      StRun: begin
        if (accel_done) begin
          cnt_d   = '0;
          state_d = StDrain;
        end else if (cnt_q == TIMEOUT_CYCLES - 1) begin
          err_d   = 1'b1;
          irq_d   = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StDrain: begin
        if (cnt_q == DRAIN_CYCLES - 1) begin
          done_d  = 1'b1;
          irq_d   = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM state, counters, flags and the latched start request
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      start_q       <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      irq           <= 1'b0;
      cnt_q         <= '0;
      filter_length <= '0;
    end else begin
      state_q       <= state_d;
      start_q       <= start_req;
      done_q        <= done_d;
      err_q         <= err_d;
      irq           <= irq_d;
      cnt_q         <= cnt_d;
      filter_length <= len_d;
    end
  end

  // Configuration registers, frozen while a job is in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      image_dim            <= '0;
      image_depth          <= '0;
      image_memory_offset  <= '0;
      filter_memory_offset <= '0;
      filter_halfsize      <= '0;
      filter_stride        <= '0;
      filter_bias          <= '0;
    end else if (cfg_wr) begin
      unique case (addr)
        AddrImageDim:   image_dim            <= wr_data[DimW-1:0];
        AddrImageDepth: image_depth          <= wr_data[DepthW-1:0];
        AddrImageOff:   image_memory_offset  <= wr_data[OffsetW-1:0];
        AddrFilterOff:  filter_memory_offset <= wr_data[OffsetW-1:0];
        AddrFilterCfg: begin
          filter_stride   <= wr_data[4:2];
          filter_halfsize <= wr_data[1:0];
        end
        AddrBias:       filter_bias          <= wr_data[BiasW-1:0];
        default: ;
      endcase
    end
  end

  // Read-data mux including the status word
  always_comb begin
    status                           = '0;
    status[StatusBusyBit]            = busy;
    status[StatusDoneBit]            = done_q;
    status[StatusErrBit]             = err_q;
    status[StatusLenLsb +: LengthW]  = filter_length;
    rd_mux = '0;
    unique case (addr)
      AddrImageDim:   rd_mux[DimW-1:0]    = image_dim;
      AddrImageDepth: rd_mux[DepthW-1:0]  = image_depth;
      AddrImageOff:   rd_mux[OffsetW-1:0] = image_memory_offset;
      AddrFilterOff:  rd_mux[OffsetW-1:0] = filter_memory_offset;
      AddrFilterCfg:  rd_mux[4:0]         = {filter_stride, filter_halfsize};
      AddrBias:       rd_mux[BiasW-1:0]   = filter_bias;
      AddrStatus:     rd_mux              = status;
      default:        rd_mux              = '0;
    endcase
  end

  // Registered read port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= rd_mux;
    end
  end

endmodule

// File: doc/accel_launcher.md
# accel_launcher

Host-side control block for the `Accel` convolution engine. It accepts job parameters from the CPU over a small register-write port, computes the derived `filter_length` so the CPU no longer has to, and drives `Accel`'s configuration inputs and active-high `rst`. It then waits for `accel_done`, holds off for a drain window because `done` is raised before the last output value lands, and reports completion through a status register and an interrupt pulse.

## Interface
- `DRAIN_CYCLES`, default 10: cycles waited after `accel_done` before the job is reported complete (100 ns at 10 ns clock).
- `TIMEOUT_CYCLES`, default 65535: maximum cycles in RUN before the job is aborted with an error.
- `clk  in  1`: single clock.
- `rst  in  1`: reset, asynchronous, active-low.
- `wr_en  in  1`: CPU register write strobe.
- `rd_en  in  1`: CPU register read strobe.
- `addr  in  3`: register address.
- `wr_data  in  32`: write data.
- `rd_data  out  32`: read data, registered.
- `irq  out  1`: one-cycle pulse on job completion or error.
- `accel_rst  out  1`: drives `Accel.rst`. Active-high.
- `image_dim  out  8`, `image_depth  out  9`, `image_memory_offset  out  16`, `filter_memory_offset  out  16`, `filter_halfsize  out  2`, `filter_stride  out  3`, `filter_length  out  13`, `filter_bias  out  18`: configuration outputs to `Accel`.
- `accel_done  in  1`: from `Accel`.

## Operation
- Register map, by `addr`:
  - 0: `image_dim[7:0]`
  - 1: `image_depth[8:0]`
  - 2: image offset `[15:0]`
  - 3: filter offset `[15:0]`
  - 4: `{stride[4:2], halfsize[1:0]}`
  - 5: `bias[17:0]`
  - 6: control (write-only). Bit0 = start, bit1 = clear status.
  - 7: status (read-only). Bit0 = busy, bit1 = done, bit2 = err, `[28:16]` = `filter_length`.
- Writes to addresses 0–5 while busy are ignored. Config outputs remain stable for the entire job.
- FSM states and transitions:
  - **IDLE**: start moves to CHECK.
  - **CHECK** (1 cycle): `image_dim == 0`, `image_depth == 0`, or `stride == 0` sets err, pulses irq, and returns to IDLE. Otherwise moves to CALC.
  - **CALC** (6 cycles): computes `filter_length = depth * k²` with `k = 2*halfsize + 1`, so `k²` ∈ {1, 9, 25, 49}. The product uses a shift-add over the 6 bits of `k²`, one bit per cycle, with a 15-bit accumulator. A result above 8191 sets err, pulses irq, and returns to IDLE.
  - **LAUNCH** (1 cycle): `accel_rst` is still 1.
  - **RUN**: `accel_rst` = 0. `accel_done` moves to DRAIN. A timeout counter reaching `TIMEOUT_CYCLES` sets err, pulses irq, reasserts `accel_rst`, and returns to IDLE.
  - **DRAIN**: counts `DRAIN_CYCLES`, ignoring further `accel_done`, then moves to DONE.
  - **DONE** (1 cycle): `accel_rst` = 1, done = 1, irq pulse, then IDLE.
- busy = 1 in every state other than IDLE.
- Start while busy is ignored.
- Clear and start written in the same cycle: clear applies first, then the job starts.
- Clear clears both done and err. done and err are sticky otherwise, and a new start does not clear them.
- Asynchronous reset mid-job aborts immediately:
  - FSM returns to IDLE.
  - `accel_rst` = 1, `irq` = 0, `rd_data` = 0.
  - All config registers and outputs = 0.
  - done and err = 0.

## Timing
- Start written at edge T:
  - CHECK at T+1.
  - CALC T+2..T+7.
  - LAUNCH T+8.
  - `accel_rst` falls at T+9.
- `accel_done` sampled high at edge D: DRAIN D+1..D+`DRAIN_CYCLES`. Then DONE, in which `accel_rst` rises, `irq` = 1, and status done = 1.
- `rd_data` is valid the cycle after `rd_en`.
- `filter_length` output updates at the end of CALC and holds until the next job's CALC completes.

## Structure
- Shared package `accel_pkg` holds:
  - register address constants (0–7)
  - status bit positions
  - FSM state enum
  - config field widths (8/9/16/2/3/13/18)
- One sub-module, `filter_length_calc`: the sequential shift-add multiplier. It has start/busy/valid handshake, a 9-bit × 6-bit operand pair, a 15-bit result and an overflow flag.

## Test plan
- **Nominal job.** Program dim 5, depth 3, offsets 0 / 1000, halfsize 1, stride 1, bias 100, then start. Required:
  - `filter_length` = 27.
  - `accel_rst` falls 9 cycles after start.
  - Model `done` after 50 cycles yields DONE 10 cycles later, with an irq pulse and status = 0x001B0002.
- **Overflow.** depth 511, halfsize 3 (product 25039). Required: err = 1, irq pulse, `accel_rst` never deasserted.
- **Invalid config.** stride 0. Required: err in CHECK, irq 2 cycles after start.
- **Writes and starts while busy.** Write dim 9 and start during RUN. Required: `image_dim` stays 5 and no second job starts.
- **Timeout.** `TIMEOUT_CYCLES` = 100 with `done` never asserted. Required: err, irq, `accel_rst` = 1 at RUN cycle 100.
- **Reset mid-job.** Assert `rst` low during DRAIN. Required: outputs at reset values immediately (asynchronously). A subsequent job completes normally.
